// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter state encoding and
// the default byte/stall timeout.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        HOLD  = 2'd3
    } arb_state_t;

    // 12 bit-times at 9600 baud with a 100 MHz clk
    localparam int TIMEOUT_CLKS_DEFAULT = 125000;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N, returned as one-hot and as an index.
module rr_select #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          any
);

    int j;

    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = PW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between N_REQ byte requesters with round-robin
// arbitration, optional packet locking and a per-byte / per-stall timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int TIMEOUT_CLKS = TIMEOUT_CLKS_DEFAULT,
    parameter bit LOCK_EN      = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    input  logic [N_REQ-1:0]   req_last_i,
    output logic [N_REQ-1:0]   req_ready_o,
    output logic [7:0]         tx_data_o,
    output logic               tx_start_o,
    input  logic               tx_done_i,
    output logic [N_REQ-1:0]   grant_o,
    output logic               busy_o,
    output logic               timeout_o
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CLKS - 1);

    arb_state_t    state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] owner;
    logic [CW-1:0] cnt;
    logic          last_q;

    logic [N_REQ-1:0] sel_onehot;
    logic [PW-1:0]    sel_idx;
    logic             sel_any;

    logic          accept;
    logic [PW-1:0] acc_idx;
    logic [7:0]    acc_data;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] i);
        return (32'(i) == N_REQ - 1) ? '0 : i + PW'(1);
    endfunction

    rr_select #(
        .N  (N_REQ),
        .PW (PW)
    ) u_rr_select (
        .req   (req_valid_i),
        .ptr   (rr_ptr),
        .grant (sel_onehot),
        .idx   (sel_idx),
        .any   (sel_any)
    );

    // Ready is combinational so the byte is accepted in the same cycle the
    // winner is chosen; it is gated by reset so nothing is taken while held.
    always_comb begin
        accept      = 1'b0;
        acc_idx     = sel_idx;
        req_ready_o = '0;
        if (reset) begin
            unique case (state)
                IDLE: begin
                    if (sel_any) begin
                        accept      = 1'b1;
                        acc_idx     = sel_idx;
                        req_ready_o = sel_onehot;
                    end
                end
                HOLD: begin
                    if (req_valid_i[owner]) begin
                        accept              = 1'b1;
                        acc_idx             = owner;
                        req_ready_o[owner]  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign acc_data = req_data_i[8*acc_idx +: 8];
    assign busy_o   = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the captured byte is a plain register, reset to zero like
            // all other state so tx_data_o is defined straight out of reset.
            state      <= IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            cnt        <= '0;
            last_q     <= 1'b0;
            tx_data_o  <= 8'h00;
            tx_start_o <= 1'b0;
            grant_o    <= '0;
            timeout_o  <= 1'b0;
        end else begin
            tx_start_o <= 1'b0;
            timeout_o  <= 1'b0;
            unique case (state)
                IDLE, HOLD: begin
                    if (accept) begin
                        owner      <= acc_idx;
                        tx_data_o  <= acc_data;
                        last_q     <= req_last_i[acc_idx];
                        grant_o    <= req_ready_o;
                        tx_start_o <= 1'b1;
                        state      <= START;
                    end else if (state == HOLD) begin
                        // Owner stalled mid-packet: keep the lock until timeout
                        if (cnt == CNT_LAST) begin
                            timeout_o <= 1'b1;
                            grant_o   <= '0;
                            last_q    <= 1'b0;
                            rr_ptr    <= next_ptr(owner);
                            state     <= IDLE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                START: begin
                    cnt   <= '0;
                    state <= BUSY;
                end
                BUSY: begin
                    // Completion wins over a coincident timeout
                    if (tx_done_i) begin
                        cnt <= '0;
                        if (LOCK_EN && !last_q) begin
                            state <= HOLD;
                        end else begin
                            rr_ptr  <= next_ptr(owner);
                            grant_o <= '0;
                            state   <= IDLE;
                        end
                    end else if (cnt == CNT_LAST) begin
                        timeout_o <= 1'b1;
                        grant_o   <= '0;
                        last_q    <= 1'b0;
                        rr_ptr    <= next_ptr(owner);
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with TIMEOUT_CLKS=50 and LOCK_EN=1.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_start;
    logic           tx_done;
    logic [N-1:0]   grant;
    logic           busy;
    logic           timeout;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ        (N),
        .TIMEOUT_CLKS (50),
        .LOCK_EN      (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .tx_data_o   (tx_data),
        .tx_start_o  (tx_start),
        .tx_done_i   (tx_done),
        .grant_o     (grant),
        .busy_o      (busy),
        .timeout_o   (timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        tx_done   = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    task automatic set_byte(input int k, input logic [7:0] d);
        req_data[8*k +: 8] = d;
    endtask

    // Expect the given ready now, then tx_start with the byte one cycle later
    task automatic accept(input string tag, input logic [3:0] exp_ready, input logic [7:0] exp_data);
        #1;
        check({tag, " ready"}, 32'(req_ready), 32'(exp_ready));
        cyc();
        check({tag, " start/grant"}, {tx_start, grant}, {1'b1, exp_ready});
        check({tag, " data"}, 32'(tx_data), 32'(exp_data));
    endtask

    task automatic finish_byte(input int busy_cycles);
        for (int i = 0; i < busy_cycles; i++) cyc();
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
    endtask

    initial begin
        logic       bad;
        logic [3:0] order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset values, with requests pending to show ready is held off
        reset = 1'b0; req_valid = 4'b1111; req_last = '0; req_data = '0; tx_done = 1'b0;
        cyc();
        cyc();
        check("reset outputs", {req_ready, tx_data, tx_start, grant, busy, timeout}, 32'd0);

        // Single byte, then pointer moves to 1
        reset = 1'b1; req_valid = 4'b0001; req_last = 4'b0001; set_byte(0, 8'h41);
        accept("single", 4'b0001, 8'h41);
        req_valid = 4'b0000;
        check("single busy", 32'(busy), 32'd1);
        finish_byte(3);
        check("single idle", {busy, grant}, 32'd0);
        req_valid = 4'b0011; set_byte(1, 8'h42); req_last = 4'b0011;
        accept("single rr", 4'b0010, 8'h42);
        req_valid = 4'b0000;
        finish_byte(2);

        // Four requesters continuously valid: 0,1,2,3,0
        do_reset();
        for (int k = 0; k < N; k++) set_byte(k, 8'hA0 + 8'(k));
        req_last = 4'b1111; req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            accept($sformatf("rr%0d", n), order[n], 8'hA0 + 8'($clog2(order[n])));
            finish_byte(19);
            check($sformatf("rr%0d done", n), {busy, grant}, 32'd0);
        end
        req_valid = '0;

        // Locked three-byte packet from req0 while req1 waits
        do_reset();
        set_byte(0, 8'h10); set_byte(1, 8'h77); req_last = 4'b0010; req_valid = 4'b0011;
        accept("lock b0", 4'b0001, 8'h10);
        set_byte(0, 8'h11);
        finish_byte(4);
        check("lock hold", {busy, grant}, {1'b1, 4'b0001});
        accept("lock b1", 4'b0001, 8'h11);
        set_byte(0, 8'h12); req_last = 4'b0011;
        finish_byte(4);
        accept("lock b2", 4'b0001, 8'h12);
        finish_byte(4);
        accept("lock next", 4'b0010, 8'h77);
        req_valid = '0;
        finish_byte(2);

        // No tx_done: timeout 50 cycles after BUSY entry, req1 next
        do_reset();
        set_byte(0, 8'h21); set_byte(1, 8'h22); req_last = 4'b0011; req_valid = 4'b0011;
        accept("to", 4'b0001, 8'h21);
        req_valid = 4'b0010;
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            bad |= timeout;
        end
        check("to early", 32'(bad), 32'd0);
        cyc();
        check("to pulse", {timeout, busy, grant}, {1'b1, 1'b0, 4'b0000});
        accept("to next", 4'b0010, 8'h22);
        check("to single pulse", 32'(timeout), 32'd0);
        req_valid = '0;
        finish_byte(2);

        // Owner drops valid in HOLD: lock kept until timeout
        do_reset();
        set_byte(0, 8'h31); set_byte(1, 8'h32); req_last = 4'b0010; req_valid = 4'b0011;
        accept("hold", 4'b0001, 8'h31);
        finish_byte(3);
        req_valid = 4'b0010;
        #1;
        bad = (req_ready != 4'b0000) || timeout || (grant != 4'b0001);
        for (int i = 0; i < 49; i++) begin
            cyc();
            bad |= (req_ready != 4'b0000) || timeout || (grant != 4'b0001);
        end
        check("hold keep lock", 32'(bad), 32'd0);
        cyc();
        check("hold timeout", {timeout, grant}, {1'b1, 4'b0000});
        accept("hold next", 4'b0010, 8'h32);
        req_valid = '0;
        finish_byte(2);

        // tx_done in the would-be timeout cycle counts as completion
        do_reset();
        set_byte(0, 8'h55); req_last = 4'b0001; req_valid = 4'b0001;
        accept("coin", 4'b0001, 8'h55);
        req_valid = '0;
        for (int i = 0; i < 50; i++) cyc();
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
        check("coin done", {timeout, busy, grant}, 32'd0);
        cyc();
        check("coin no late pulse", 32'(timeout), 32'd0);

        // tx_done ignored in START; reset mid-byte clears everything
        do_reset();
        set_byte(0, 8'h66); req_last = 4'b0001; req_valid = 4'b0001;
        accept("rst", 4'b0001, 8'h66);
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
        check("done in start ignored", {busy, grant, tx_start}, {1'b1, 4'b0001, 1'b0});
        cyc();
        reset = 1'b0;
        #1;
        check("rst ready gated", 32'(req_ready), 32'd0);
        cyc();
        check("rst outputs", {req_ready, tx_data, tx_start, grant, busy, timeout}, 32'd0);
        cyc();
        check("rst no start", {tx_start, busy}, 32'd0);
        reset = 1'b1;
        req_valid = '0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of byte requesters sharing one uart_tx (2..8).
REQ-002 SHALL have parameter TIMEOUT_CLKS, default 125000: clk cycles allowed per byte or per owner stall before forced release (12 bit-times at 9600 baud / 100 MHz).
REQ-003 SHALL have parameter LOCK_EN, default 1: 1 = owner keeps the transmitter until a byte with last set; 0 = byte-granular arbitration.
REQ-004 clk  input  1  system clock; all logic on posedge.
REQ-005 reset  input  1  synchronous, active-low.
REQ-006 req_valid_i  input  N_REQ  per-requester byte available.
REQ-007 req_data_i  input  8*N_REQ  byte of requester k at bits [8k+7:8k].
REQ-008 req_last_i  input  N_REQ  byte ends requester's packet.
REQ-009 req_ready_o  output  N_REQ  one-cycle accept strobe; byte transferred when valid and ready both high.
REQ-010 tx_data_o  output  8  byte to uart_tx tx_data_i.
REQ-011 tx_start_o  output  1  one-cycle start to uart_tx ready_i.
REQ-012 tx_done_i  input  1  uart_tx valid_o; one-cycle pulse at byte completion.
REQ-013 grant_o  output  N_REQ  one-hot current owner, zero when unowned.
REQ-014 busy_o  output  1  high in any state except IDLE.
REQ-015 timeout_o  output  1  one-cycle pulse on forced release.

Function
REQ-016 SHALL implement FSM states IDLE, START, BUSY, HOLD.
REQ-017 IDLE: if any req_valid_i set, winner = first valid index at or after rr_ptr (wrapping modulo N_REQ); same cycle req_ready_o[winner]=1, data and last captured into registers, grant_o set, next START.
REQ-018 START: tx_start_o=1 for exactly one cycle, next BUSY; tx_data_o holds the captured byte from capture until next capture.
REQ-019 BUSY: on tx_done_i, if LOCK_EN=1 and captured last=0 go HOLD, else rr_ptr <= winner+1 (mod N_REQ), grant_o cleared, go IDLE.
REQ-020 HOLD: only the owner is considered; owner valid -> accept exactly as REQ-017 (same cycle ready), go START; other requesters' ready stays 0.
REQ-021 Timeout counter SHALL clear on entry to BUSY and HOLD, increment each cycle there; reaching TIMEOUT_CLKS-1 -> timeout_o pulse, lock released, rr_ptr <= owner+1, IDLE.
REQ-022 tx_done_i coincident with the timeout cycle SHALL be treated as completion (no timeout_o).
REQ-023 tx_done_i outside BUSY SHALL be ignored.
REQ-024 Accept-to-tx_start_o latency SHALL be exactly 1 cycle; tx_done_i-to-next-accept minimum 1 cycle (IDLE/HOLD cycle).
REQ-025 At most one req_ready_o bit high in any cycle; ready never asserted while valid low.
REQ-026 A requester dropping valid while granted in HOLD SHALL not lose the lock until timeout.
REQ-027 Counter width SHALL be $clog2(TIMEOUT_CLKS+1); rr_ptr width $clog2(N_REQ).

Reset
REQ-028 reset low SHALL force IDLE, rr_ptr=0, counter=0, lock cleared, captured byte 0.
REQ-029 Reset values: req_ready_o=0, tx_data_o=8'h00, tx_start_o=0, grant_o=0, busy_o=0, timeout_o=0.
REQ-030 Reset asserted mid-byte SHALL abort without a further tx_start_o; uart_tx is reset by the same signal.

Structure
REQ-031 FSM state encoding and TIMEOUT default SHALL live in shared package uart_pkg.
REQ-032 Round-robin priority select SHALL be sub-module rr_select (request vector, pointer -> one-hot and index), combinational.
REQ-033 No other sub-modules; uart_tx instantiated by the parent, not inside this block.

Verification
REQ-034 Reset then req_valid=4'b0001, data0=8'h41, last=1 -> ready[0] one cycle, tx_start 1 cycle later with tx_data=8'h41; tx_done -> busy_o 0, rr_ptr=1.
REQ-035 All four valid, last=1 each, done 20 cycles after each start -> service order 0,1,2,3, then 0 again.
REQ-036 LOCK_EN=1, req0 sends 3 bytes (last on third) while req1 valid throughout -> req0 three bytes uninterrupted, then req1 granted.
REQ-037 TIMEOUT_CLKS=50, tx_done never returned -> timeout_o pulse 50 cycles after BUSY entry, next requester granted.
REQ-038 tx_done and timeout in same cycle -> no timeout_o, normal completion; reset pulled low in BUSY -> all outputs zero next cycle.
